// File: rtl/pwm_meas.sv
// pwm_meas: measures high time and period of an asynchronous PWM input in clk_i cycles,
// flagging a stuck input when no edge arrives before the counters saturate.
module pwm_meas #(
  parameter int SIZE_OF_VALUE = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     pwm_i,
  output logic [SIZE_OF_VALUE:0]   value_o,
  output logic [SIZE_OF_VALUE:0]   period_o,
  output logic                     valid_o,
  output logic                     stuck_o,
  output logic                     level_o
);
  localparam int CW = SIZE_OF_VALUE + 1;
  localparam logic [CW-1:0] MAX = '1;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic s1, s2, h;
  logic [2:0] sv;
  logic [CW-1:0] hc_q, hc_d, pc_q, pc_d, value_d, period_d;
  logic valid_d, stuck_d, level_d, rise, fall, tmo;
  // rise is masked until the history flop holds a real sample, so reset cannot fake an edge
  assign rise = s2 & ~h & sv[2];
  assign fall = ~s2 & h;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      {s1, s2, h, sv} <= '0;
      state_q <= IDLE;
      hc_q <= '0;
      pc_q <= '0;
      value_o <= '0;
      period_o <= '0;
      valid_o <= 1'b0;
      stuck_o <= 1'b0;
      level_o <= 1'b0;
    end else begin
      {h, s2, s1} <= {s2, s1, pwm_i};
      sv <= {sv[1:0], 1'b1};
      state_q <= state_d;
      hc_q <= hc_d;
      pc_q <= pc_d;
      value_o <= value_d;
      period_o <= period_d;
      valid_o <= valid_d;
      stuck_o <= stuck_d;
      level_o <= level_d;
    end
  end
  always_comb begin
    state_d = state_q;
    hc_d = hc_q;
    pc_d = pc_q;
    value_d = value_o;
    period_d = period_o;
    stuck_d = stuck_o;
    level_d = level_o;
    valid_d = 1'b0;
    tmo = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      hc_d = '0;
      pc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          hc_d = '0;
          pc_d = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            hc_d = 1;
            pc_d = 1;
          end else if (pc_q == MAX) tmo = 1'b1;
          else pc_d = pc_q + 1'b1;
        end
        HIGH: begin
          if (pc_q == MAX) tmo = 1'b1;
          else if (fall) begin
            state_d = LOW;
            pc_d = pc_q + 1'b1;
          end else begin
            hc_d = hc_q + 1'b1;
            pc_d = pc_q + 1'b1;
          end
        end
        default: begin
          if (rise) begin
            state_d = HIGH;
            value_d = hc_q;
            period_d = pc_q;
            stuck_d = 1'b0;
            level_d = 1'b0;
            valid_d = 1'b1;
            hc_d = 1;
            pc_d = 1;
          end else if (pc_q == MAX) tmo = 1'b1;
          else pc_d = pc_q + 1'b1;
        end
      endcase
    end
    // a timeout restarts the wait at 1 so repeated stuck results are exactly MAX cycles apart
    if (tmo) begin
      state_d = ARM;
      hc_d = '0;
      pc_d = 1;
      value_d = {CW{s2}};
      period_d = MAX;
      stuck_d = 1'b1;
      level_d = s2;
      valid_d = 1'b1;
    end
  end
endmodule
